// File: rtl/intc_subsystem.sv
// intc_subsystem: memory-mapped 4-source interrupt controller.
//   clk, rst          : clock, synchronous active-high reset
//   done[3:0]         : accelerator request lines (rising edge = request)
//   IACK              : CPU acknowledge, clears the currently selected source
//   input_addr        : bus address for reads and writes (base 0x00020000)
//   write_enable      : bus write strobe
//   write_data        : bus write data
//   read_data         : combinational read of the ISR table (0 when out of range)
//   IRQ               : any request pending
//   isr_addr          : ISR address of lowest-index pending source (0 if none)
//   error             : one-cycle pulse on spurious acknowledge or lost request
module intc_subsystem (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  done,
  input  logic        IACK,
  input  logic [31:0] input_addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        IRQ,
  output logic [31:0] isr_addr,
  output logic        error
);
  localparam int NUM_SRC = 4;

  logic [NUM_SRC-1:0][31:0] isr_tab;
  logic [NUM_SRC-1:0]       pending;
  logic [NUM_SRC-1:0]       done_q;
  logic                     error_q;

  logic                     in_range;
  logic [1:0]               idx;
  logic [1:0]               sel;
  logic                     ack;
  logic [NUM_SRC-1:0]       clr;
  logic [NUM_SRC-1:0]       rise;
  logic                     lost;
  logic                     spurious;

  // Bus decode: window 0x00020000..0x0002000F, word index in bits [3:2].
  assign in_range = (input_addr[31:16] == 16'h0002) && (input_addr[15:4] == 12'h000);
  assign idx      = input_addr[3:2];

  // ISR table, one write-enabled register per source.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_tab
    always_ff @(posedge clk) begin
      if (rst)
        isr_tab[i] <= '0;
      else if (write_enable && in_range && (idx == 2'(i)))
        isr_tab[i] <= write_data;
    end
  end

  assign read_data = in_range ? isr_tab[idx] : 32'h0;

  // Lowest index wins.
  always_comb begin
    sel = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pending[i]) sel = 2'(i);
  end

  assign IRQ      = |pending;
  assign isr_addr = IRQ ? isr_tab[sel] : 32'h0;

  assign ack  = IACK & IRQ;
  assign rise = done & ~done_q;

  always_comb begin
    clr = '0;
    if (ack) clr[sel] = 1'b1;
  end

  // A new edge on a source that is already pending and not being cleared
  // this cycle would be merged into the existing request: flag it.
  assign lost     = |(rise & pending & ~clr);
  assign spurious = IACK & ~IRQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= '0;
      pending <= '0;
      error_q <= 1'b0;
    end else begin
      done_q  <= done;
      // Set has priority over clear on the same source.
      pending <= (pending & ~clr) | rise;
      error_q <= lost | spurious;
    end
  end

  assign error = error_q;

endmodule

// File: tb/tb_intc_subsystem.sv
module tb_intc_subsystem;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  done;
  logic        IACK;
  logic [31:0] input_addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        IRQ;
  logic [31:0] isr_addr;
  logic        error;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  intc_subsystem dut (
    .clk(clk), .rst(rst), .done(done), .IACK(IACK),
    .input_addr(input_addr), .write_enable(write_enable), .write_data(write_data),
    .read_data(read_data), .IRQ(IRQ), .isr_addr(isr_addr), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Table as an int-indexed array, requests as a list of flags; selection
  // is "first raised flag", error is a rule evaluated per edge.
  logic [31:0] m_tab [4];
  bit          m_req [4];
  bit          m_prev[4];
  bit          m_err;

  function automatic bit m_any();
    foreach (m_req[i]) if (m_req[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_first();
    foreach (m_req[i]) if (m_req[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a >= 32'h0002_0000 && a < 32'h0002_0010) return m_tab[(a - 32'h0002_0000) / 4];
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    int  s;
    bit  acked;
    bit  e;
    bit  nreq[4];
    if (rst) begin
      foreach (m_tab[i]) begin
        m_tab[i]  <= 32'h0;
        m_req[i]  <= 1'b0;
        m_prev[i] <= 1'b0;
      end
      m_err <= 1'b0;
      armed <= 1'b1;
    end else begin
      s     = m_first();
      acked = IACK && (s >= 0);
      e     = IACK && (s < 0);
      nreq  = m_req;
      if (acked) nreq[s] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (done[i] && !m_prev[i]) begin
          if (m_req[i] && !(acked && s == i)) e = 1'b1;
          nreq[i] = 1'b1;
        end
        m_prev[i] <= done[i];
      end
      m_req <= nreq;
      m_err <= e;
      if (write_enable && input_addr >= 32'h0002_0000 && input_addr < 32'h0002_0010)
        m_tab[(input_addr - 32'h0002_0000) / 4] <= write_data;
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_irq",   {31'b0, IRQ},   {31'b0, m_any()});
      chk("cyc_isr",   isr_addr,       m_any() ? m_tab[m_first()] : 32'h0);
      chk("cyc_err",   {31'b0, error}, {31'b0, m_err});
      chk("cyc_rdata", read_data,      m_read(input_addr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    input_addr = a; write_data = d; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    input_addr = a;
    #1;
    chk(name, read_data, exp);
  endtask

  initial begin
    rst = 1'b1; done = 4'b0; IACK = 1'b0;
    input_addr = 32'h0002_0000; write_enable = 1'b0; write_data = 32'h0;
    step(); step();
    chk("rst_irq", {31'b0, IRQ}, 32'h0);
    chk("rst_isr", isr_addr, 32'h0);
    chk("rst_err", {31'b0, error}, 32'h0);
    chk("rst_rd",  read_data, 32'h0);
    rst = 1'b0;
    step();

    // Table programming and readback
    wr(32'h0002_0000, 32'h100);
    wr(32'h0002_0004, 32'h200);
    wr(32'h0002_0008, 32'h300);
    wr(32'h0002_000C, 32'h400);
    wr(32'h0003_0004, 32'hDEAD);   // out of range, ignored
    rd("rd_t0", 32'h0002_0000, 32'h100);
    rd("rd_t1", 32'h0002_0004, 32'h200);
    rd("rd_t2", 32'h0002_0008, 32'h300);
    rd("rd_t3", 32'h0002_000C, 32'h400);
    rd("rd_lowbits", 32'h0002_0007, 32'h200);
    rd("rd_oor", 32'h0002_0010, 32'h0);
    rd("rd_oor_hi", 32'h0003_0004, 32'h0);
    chk("idle_irq", {31'b0, IRQ}, 32'h0);
    chk("idle_isr", isr_addr, 32'h0);

    // Single request on source 2
    done = 4'b0100; step(); done = 4'b0;
    chk("s2_irq", {31'b0, IRQ}, 32'h1);
    chk("s2_isr", isr_addr, 32'h300);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("s2_ack_irq", {31'b0, IRQ}, 32'h0);
    chk("s2_ack_isr", isr_addr, 32'h0);
    chk("s2_ack_err", {31'b0, error}, 32'h0);

    // Simultaneous sources 3 and 1
    done = 4'b1010; step(); done = 4'b0;
    chk("pri_isr1", isr_addr, 32'h200);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("pri_irq3", {31'b0, IRQ}, 32'h1);
    chk("pri_isr3", isr_addr, 32'h400);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("pri_irq0", {31'b0, IRQ}, 32'h0);

    // Spurious acknowledge
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("spur_err", {31'b0, error}, 32'h1);
    chk("spur_irq", {31'b0, IRQ}, 32'h0);
    step();
    chk("spur_err_end", {31'b0, error}, 32'h0);

    // Lost interrupt on source 0
    done = 4'b0001; step(); done = 4'b0; step();
    done = 4'b0001; step(); done = 4'b0;
    chk("lost_err", {31'b0, error}, 32'h1);
    step();
    chk("lost_err_end", {31'b0, error}, 32'h0);
    chk("lost_isr", isr_addr, 32'h100);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("lost_once", {31'b0, IRQ}, 32'h0);

    // Level-held request on source 1
    done = 4'b0010;
    for (int i = 0; i < 10; i++) step();
    chk("hold_isr", isr_addr, 32'h200);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("hold_ack", {31'b0, IRQ}, 32'h0);
    step(); step(); step();
    chk("hold_quiet", {31'b0, IRQ}, 32'h0);
    done = 4'b0; step();
    done = 4'b0010; step(); done = 4'b0;
    chk("hold_rearm", {31'b0, IRQ}, 32'h1);
    IACK = 1'b1; step(); IACK = 1'b0;

    // Set wins over acknowledge of the same source
    done = 4'b0100; step(); done = 4'b0; step();
    done = 4'b0100; IACK = 1'b1; step(); done = 4'b0; IACK = 1'b0;
    chk("setwin_irq", {31'b0, IRQ}, 32'h1);
    chk("setwin_isr", isr_addr, 32'h300);
    chk("setwin_err", {31'b0, error}, 32'h0);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("setwin_clr", {31'b0, IRQ}, 32'h0);

    // Live table rewrite while source 0 pending, then reset mid-service
    done = 4'b0001; step(); done = 4'b0;
    chk("rw_before", isr_addr, 32'h100);
    wr(32'h0002_0000, 32'hABC);
    chk("rw_after", isr_addr, 32'hABC);
    rst = 1'b1; done = 4'b0010; IACK = 1'b1;
    input_addr = 32'h0002_0004; write_data = 32'h5555; write_enable = 1'b1;
    step();
    rst = 1'b0; IACK = 1'b0; write_enable = 1'b0;
    chk("mrst_irq", {31'b0, IRQ}, 32'h0);
    chk("mrst_isr", isr_addr, 32'h0);
    rd("mrst_t0", 32'h0002_0000, 32'h0);
    rd("mrst_t1", 32'h0002_0004, 32'h0);
    rd("mrst_t2", 32'h0002_0008, 32'h0);
    rd("mrst_t3", 32'h0002_000C, 32'h0);
    // done[1] held through reset counts as a fresh edge
    step();
    chk("post_rst_irq", {31'b0, IRQ}, 32'h1);
    chk("post_rst_isr", isr_addr, 32'h0);
    done = 4'b0;
    IACK = 1'b1; step(); IACK = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
